// File: rtl/regfile_ram_2r1w.sv
// regfile_ram_2r1w: 2-read / 1-write register-bank RAM.
//   - Registered reads (one-cycle latency) on two independent ports R0/R1.
//   - Byte-masked writes on W0; per-entry valid bits; one-cycle bulk clear.
//   - Entries that were never written, or were cleared, read as zero.
// Build option: define REGFILE_RAM_BYPASS_EN to return the freshly merged
// write data on a same-cycle, same-address read (write-first). Without it the
// read returns the pre-write contents (read-first).
module regfile_ram_2r1w #(
  parameter  int DEPTH  = 512,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic [DATA_W-1:0] W0_data,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_valid,
  input  logic              R1_en,
  input  logic [ADDR_W-1:0] R1_addr,
  output logic [DATA_W-1:0] R1_data,
  output logic              R1_valid,
  input  logic              clr_all
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  entry_valid;

  // A write with an all-zero mask changes neither the array nor the valid bit.
  logic              wr_fire;
  logic [DATA_W-1:0] wr_base;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd0_next;
  logic [DATA_W-1:0] rd1_next;

  assign wr_fire = W0_en && (|W0_mask);

  // Merge W0 bytes over the current entry, or over zero when the entry is
  // invalid or being cleared this cycle (so masked-off bytes come out as 0).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    wr_base   = (entry_valid[W0_addr] && !clr_all) ? mem[W0_addr] : '0;
    wr_merged = wr_base;
    for (int i = 0; i < MASK_W; i++) begin
      if (W0_mask[i]) wr_merged[8*i +: 8] = W0_data[8*i +: 8];
    end
  end

  // Next read data for both ports: stored word gated by its valid bit,
  // optionally overridden by the same-cycle write.
  always_comb begin
    rd0_next = entry_valid[R0_addr] ? mem[R0_addr] : '0;
    rd1_next = entry_valid[R1_addr] ? mem[R1_addr] : '0;
`ifdef REGFILE_RAM_BYPASS_EN
    if (wr_fire && (R0_addr == W0_addr)) rd0_next = wr_merged;
    if (wr_fire && (R1_addr == W0_addr)) rd1_next = wr_merged;
`endif
  end

  // Array storage: written only on a firing write, never reset.
  always_ff @(posedge clock) begin
    // NOTE: the data array has no reset; validity is tracked by entry_valid,
    // which keeps the array mappable onto plain RAM cells.
    if (wr_fire) mem[W0_addr] <= wr_merged;
  end

  // Per-entry valid bits: bulk clear, then a firing write sets its entry
  // (the later assignment wins, so a write survives a simultaneous clear).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry_valid <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (clr_all) entry_valid <= '0;
      if (wr_fire) entry_valid[W0_addr] <= 1'b1;
    end
  end

  // Read port 0 output register: capture on request, hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      R0_data  <= '0;
      R0_valid <= 1'b0;
    end else begin
      R0_valid <= R0_en;
      if (R0_en) R0_data <= rd0_next;
    end
  end

  // Read port 1 output register: capture on request, hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      R1_data  <= '0;
      R1_valid <= 1'b0;
    end else begin
      R1_valid <= R1_en;
      if (R1_en) R1_data <= rd1_next;
    end
  end

endmodule
